// File: rtl/moore_seq_detector.sv
// Programmable Moore pattern detector: matches the last `len` serial bits against `pat`,
// holds a registered match output, and keeps a saturating match counter.
module moore_seq_detector #(
    parameter int             N       = 8,
    parameter int             CNT_W   = 16,
    parameter logic [N-1:0]   DEF_PAT = N'(4'b0101),
    parameter int             DEF_LEN = 4,
    parameter logic           DEF_OVL = 1'b1,
    localparam int            LW      = $clog2(N) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             x,
    input  logic             cfg_we,
    input  logic [N-1:0]     cfg_pattern,
    input  logic [LW-1:0]    cfg_len,
    input  logic             cfg_overlap,
    input  logic             count_clr,
    output logic             outp,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] match_count
);
    // state | meaning
    // FILL  | collecting bits until `len` valid bits are held
    // HUNT  | history full, no match on the newest window
    // MATCH | newest window equals the pattern (outp high)
    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_HUNT  = 2'd1;
    localparam logic [1:0] S_MATCH = 2'd2;
    localparam logic [1:0] S_ILL   = 2'd3;

    localparam logic [LW-1:0] LEN_MAX = LW'(N);
    localparam logic [LW-1:0] LEN_ONE = LW'(1);
    localparam logic [LW-1:0] LEN_DEF = LW'(DEF_LEN);

    logic [1:0]    state, state_n;
    logic [N-1:0]  hist, hist_n, pat, len_mask;
    logic [LW-1:0] fill, fill_n, len, len_cfg;
    logic          ovl, hit, match_ev;

    always_comb begin
        len_cfg = cfg_len;
        if (cfg_len == '0) begin
            len_cfg = LEN_ONE;
        end else if (cfg_len > LEN_MAX) begin
            len_cfg = LEN_MAX;
        end
    end

    assign len_mask = {N{1'b1}} >> (LEN_MAX - len);

    always_comb begin
        hist_n  = (hist << 1) | N'(x);
        fill_n  = (fill < len) ? fill + LEN_ONE : len;
        hit     = (fill_n == len) && ((hist_n & len_mask) == (pat & len_mask));
        state_n = state;
        case (state)
            S_FILL: begin
                if (hit) begin
                    state_n = S_MATCH;
                end else if (fill_n == len) begin
                    state_n = S_HUNT;
                end
            end
            S_HUNT: begin
                if (hit) begin
                    state_n = S_MATCH;
                end
            end
            S_MATCH: begin
                if (ovl) begin
                    state_n = hit ? S_MATCH : S_HUNT;
                end else begin
                    // Non-overlap: the completing window is consumed, only the new bit survives.
                    fill_n  = LEN_ONE;
                    hit     = (len == LEN_ONE) && (x == pat[0]);
                    state_n = hit ? S_MATCH : S_FILL;
                end
            end
            default: begin
                hit     = 1'b0;
                state_n = S_FILL;
            end
        endcase
    end

    assign match_ev = en && !cfg_we && (state != S_ILL) && (state_n == S_MATCH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_FILL;
            hist        <= '0;
            fill        <= '0;
            pat         <= DEF_PAT;
            len         <= LEN_DEF;
            ovl         <= DEF_OVL;
            match_count <= '0;
        end else begin
            if (cfg_we) begin
                pat   <= cfg_pattern;
                len   <= len_cfg;
                ovl   <= cfg_overlap;
                hist  <= '0;
                fill  <= '0;
                state <= S_FILL;
            end else if (state == S_ILL) begin
                fill  <= '0;
                state <= S_FILL;
            end else if (en) begin
                hist  <= hist_n;
                fill  <= fill_n;
                state <= state_n;
            end

            if (count_clr) begin
                match_count <= '0;
            end else if (match_ev && !(&match_count)) begin
                match_count <= match_count + 1'b1;
            end
        end
    end

    assign outp    = (state == S_MATCH);
    assign state_o = state;

endmodule

// File: tb/tb_moore_seq_detector.sv
// Scoreboard bench for moore_seq_detector: a bit-queue reference model predicts each
// post-edge output; a monitor process pops and compares after every clock edge.
module tb_moore_seq_detector;
    localparam int N     = 8;
    localparam int LW    = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             en = 1'b0;
    logic             x = 1'b0;
    logic             cfg_we = 1'b0;
    logic [N-1:0]     cfg_pattern = '0;
    logic [LW-1:0]    cfg_len = '0;
    logic             cfg_overlap = 1'b0;
    logic             count_clr = 1'b0;
    logic             outp;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] match_count;

    moore_seq_detector #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .en(en), .x(x), .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .count_clr(count_clr), .outp(outp), .state_o(state_o), .match_count(match_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       o;
        logic [1:0] s;
        logic [3:0] c;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: the valid history as a queue of bits, oldest first.
    bit       hb[$];
    bit [7:0] m_pat;
    int       m_len;
    bit       m_ovl;
    int       m_state;
    int       m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic bit pat_eq();
        for (int i = 0; i < m_len; i++) begin
            if (hb[m_len - 1 - i] != m_pat[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        hb.delete();
        m_pat   = 8'b0101;
        m_len   = 4;
        m_ovl   = 1'b1;
        m_state = 0;
        m_cnt   = 0;
    endtask

    task automatic drive(input logic e, input logic xb, input logic we, input logic [N-1:0] p,
                         input logic [LW-1:0] l, input logic o, input logic clr);
        bit   hit;
        bit   brk;
        int   ns;
        exp_t ev;
        @(negedge clk);
        en = e; x = xb; cfg_we = we; cfg_pattern = p; cfg_len = l; cfg_overlap = o; count_clr = clr;
        hit = 1'b0;
        ns  = m_state;
        if (we) begin
            m_pat = p;
            m_len = (l == 0) ? 1 : ((int'(l) > N) ? N : int'(l));
            m_ovl = o;
            hb.delete();
            ns = 0;
        end else if (e) begin
            brk = (m_state == 2) && !m_ovl;
            if (brk) hb.delete();
            hb.push_back(xb);
            if (hb.size() > m_len) void'(hb.pop_front());
            hit = (hb.size() == m_len) && pat_eq();
            if (hit)                     ns = 2;
            else if (brk)                ns = 0;
            else if (hb.size() == m_len) ns = 1;
            else                         ns = 0;
        end
        m_state = ns;
        if (clr)                        m_cnt = 0;
        else if (hit && m_cnt != CMAX)  m_cnt++;
        ev.o = (ns == 2);
        ev.s = 2'(ns);
        ev.c = 4'(m_cnt);
        exp_q.push_back(ev);
    endtask

    task automatic bit_in(input logic b);
        drive(1'b1, b, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic cfg(input logic [N-1:0] p, input logic [LW-1:0] l, input logic o);
        drive(1'b0, 1'b0, 1'b1, p, l, o, 1'b0);
    endtask

    task automatic bits_in(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) bit_in(v[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("reset_outp", 32'(outp), 32'd0);
        chk("reset_state_o", 32'(state_o), 32'd0);
        chk("reset_match_count", 32'(match_count), 32'd0);
        en = 1'b0; cfg_we = 1'b0; count_clr = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin : monitor
        exp_t ev;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && exp_q.size() > 0) begin
                ev = exp_q.pop_front();
                chk("outp", 32'(outp), 32'(ev.o));
                chk("state_o", 32'(state_o), 32'(ev.s));
                chk("match_count", 32'(match_count), 32'(ev.c));
            end
        end
    end

    initial begin : stimulus
        model_reset();
        do_reset();

        bits_in(16'b0101, 4);
        idle(); bit_in(1'b0);

        cfg(8'b0101, 4'd4, 1'b1);
        bits_in(16'b010101, 6);
        cfg(8'b0101, 4'd4, 1'b0);
        bits_in(16'b010101, 6);

        cfg(8'hA5, 4'd8, 1'b1);
        bits_in(16'hA5A5, 16);
        cfg(8'hA5, 4'd8, 1'b0);
        bits_in(16'hA5A5, 16);
        cfg(8'hA5, 4'd8, 1'b1);
        bits_in(16'hA5, 8);
        repeat (3) idle();
        bits_in(16'hA5, 8);
        repeat (3) idle();
        bits_in(16'h5, 4);
        repeat (3) idle();
        bits_in(16'hA, 4);

        cfg(8'h01, 4'd1, 1'b0);
        bits_in(16'b1110, 4);
        cfg(8'h01, 4'd0, 1'b0);
        bits_in(16'b1101, 4);
        cfg(8'hA5, 4'd15, 1'b1);
        bits_in(16'hA5A5, 16);

        cfg(8'h01, 4'd1, 1'b1);
        repeat (20) bit_in(1'b1);
        drive(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
        bit_in(1'b1);

        cfg(8'b0101, 4'd4, 1'b1);
        bits_in(16'b010, 3);
        drive(1'b1, 1'b1, 1'b1, 8'b0101, 4'd4, 1'b1, 1'b0);
        bit_in(1'b1);

        bits_in(16'b010, 3);
        do_reset();
        bit_in(1'b1);
        bits_in(16'b0101, 4);
        do_reset();

        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2)
                cfg(N'($urandom), LW'($urandom_range(0, 15)), 1'($urandom));
            else if (r < 4)
                drive(1'b1, 1'($urandom), 1'b0, '0, '0, 1'b0, 1'b1);
            else if (r < 15)
                idle();
            else
                bit_in(1'($urandom));
        end

        repeat (3) idle();
        @(negedge clk);
        en = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/moore_seq_detector.md
# moore_seq_detector

Parametrised Moore-style serial pattern detector: the runtime-programmable successor of the team's fixed four-state sequence FSM. It samples one serial bit per enabled clock, compares the most recent `len` bits against a programmable pattern of up to `N` bits, and raises a registered Moore output while a match is held. It supports overlapping or non-overlapping detection and keeps a saturating match counter. It sits on serial control/status lines, between the bit source and downstream event logic.

## Interface
- `N`, default 8: maximum pattern length in bits (≥1).
- `CNT_W`, default 16: width of the match counter.
- `DEF_PAT`, default `'b0101`: reset pattern, `N` bits wide.
- `DEF_LEN`, default 4: reset pattern length.
- `DEF_OVL`, default 1: reset overlap mode.
- `LW` (derived): `$clog2(N)+1`.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high; clock `clk`.
- `en`, in, 1: when high, `x` is sampled this cycle.
- `x`, in, 1: serial data bit.
- `cfg_we`, in, 1: load configuration this cycle.
- `cfg_pattern`, in, N: pattern; bit `len-1` is the oldest bit, bit 0 the newest.
- `cfg_len`, in, LW: pattern length. 0 is treated as 1; values greater than `N` are treated as `N`.
- `cfg_overlap`, in, 1: 1 = overlapping matches allowed.
- `count_clr`, in, 1: synchronous clear of `match_count`.
- `outp`, out, 1: Moore output, high while state is MATCH.
- `state_o`, out, 2: current state. FILL=0, HUNT=1, MATCH=2.
- `match_count`, out, CNT_W: number of match events, saturating.

## Operation
- Internal registers:
  - `hist[N-1:0]`: shift register; the newest bit enters at bit 0.
  - `fill`: 0..len; number of valid history bits.
  - `pat`, `len`, `ovl`: active configuration.
- Reset (asynchronous): state=FILL, `hist`=0, `fill`=0, `pat`=DEF_PAT, `len`=DEF_LEN, `ovl`=DEF_OVL, `outp`=0, `state_o`=0, `match_count`=0.
- Sampled step, when `en`=1: `hist' = {hist[N-2:0], x}` and `fill' = min(fill+1, len)`. Define `hit = (fill'==len) && (hist'[len-1:0] == pat[len-1:0])`.
- Transitions, evaluated only when `en`=1; with `en`=0 all state holds (including MATCH, so `outp` stays high):
  - FILL: `hit` → MATCH; else `fill'==len` → HUNT; else stay in FILL.
  - HUNT: `hit` → MATCH; else stay in HUNT.
  - MATCH with `ovl`=1: behaves as HUNT on `hist'`. `hit` → MATCH; else HUNT.
  - MATCH with `ovl`=0: the completing bits are discarded and `fill'` is forced to 1 (only the new bit is valid). If `len`=1 and the new bit equals `pat[0]` → MATCH; else FILL.
  - Illegal encoding 3: go to FILL on the next clock and clear `fill`.
- Match event: any sampled step where the next state is MATCH. This includes MATCH→MATCH.
- On a match event, `match_count` increments by 1 and saturates at all-ones.
- `count_clr`=1 sets `match_count` to 0. When it coincides with a match event, the clear wins and the event is not counted.
- `cfg_we`=1 loads `pat`, `len` (clamped), and `ovl`, clears `hist` and `fill`, and sets state=FILL. It has priority over `en`; the `x` presented that cycle is dropped. `match_count` is unaffected.
- `outp = (state == MATCH)`. It is a registered output with no combinational path from `x`.

## Timing
- Latency: the bit that completes a pattern is sampled at edge k. `outp` is high from edge k until the next enabled sample that leaves MATCH.
- With continuous `en`, an isolated match produces exactly one `outp` cycle.
- In overlap mode, back-to-back matches keep `outp` high continuously, and `match_count` increments on every one of them.
- `cfg_we` at edge k: the first bit counted toward the new pattern is the one sampled at edge k+1 or later.
- Reset asserted mid-stream: all outputs drop to their reset values immediately, without waiting for a clock edge. Operation resumes on the first clock after reset is released, using the DEF_* configuration.

## Test plan
- Defaults after reset, `en`=1, stream 0,1,0,1 → `outp` high for exactly the cycle after the 4th bit; `match_count`=1; `state_o` sequence 0,0,0,0,2.
- Overlap: `cfg_len`=4, `cfg_pattern`=`'b0101`, `ovl`=1, stream 0,1,0,1,0,1 → `outp` high after bit 4 and again after bit 6 (low after bit 5); `match_count`=2. The same stream with `ovl`=0 → one match; `match_count`=1.
- `N`=8, `len`=8, `pat`=`'hA5`, stream `'hA5A5` → 2 matches with `ovl`=1 or 0. Toggling `en` low for 3 cycles mid-stream → same result; `outp` held high throughout the gap if the gap falls while in MATCH.
- `len`=1, `pat`=1, `ovl`=0, stream 1,1,1 → `outp` high for 3 consecutive cycles; `match_count`=3. `cfg_len`=0 → behaves identically. `cfg_len`=15 with `N`=8 → behaves as `len`=8.
- Saturation and clear: `CNT_W`=2, drive 5 matches → `match_count` stops at 3. `count_clr` in the same cycle as a match event → `match_count`=0.
- Disturbances:
  - `cfg_we` in the same cycle as a completing bit → no match, state=FILL.
  - `reset` asserted mid-pattern (after 0,1,0) → `outp`=0 and `state_o`=0 immediately.
  - After release, a fresh 0,1,0,1 is required for a match.
